// File: rtl/mux2_burst_arbiter.sv
// Round-robin burst arbiter producing the 2:1 mux select, with a one-entry registered output stage.
// Optional per-source accepted-beat counters are built when MUX2_ARB_GRANT_CNT_EN is defined.
`timescale 1ns/1ps
module mux2_burst_arbiter #(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef MUX2_ARB_GRANT_CNT_EN
  ,
  input  logic             cnt_clr,
  output logic [15:0]      a_grant_cnt,
  output logic [15:0]      b_grant_cnt
`endif
);

  localparam logic [7:0] LAST_BEAT = 8'(BURST - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  state_t           state_r;
  logic             sel_r;
  logic             last_b_r;
  logic [7:0]       beat_cnt_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;

  logic space_s;
  logic a_ready_s;
  logic b_ready_s;
  logic a_acc_s;
  logic b_acc_s;
  logic at_last_s;
  logic go_a_s;
  logic go_b_s;
  logic go_idle_s;

  // Handshake qualification: a grant only accepts when the output register can take a beat.
  always_comb begin
    space_s   = 1'b0;
    a_ready_s = 1'b0;
    b_ready_s = 1'b0;
    a_acc_s   = 1'b0;
    b_acc_s   = 1'b0;
    at_last_s = 1'b0;
    space_s   = !out_valid_r || out_ready;
    a_ready_s = (state_r == GNT_A) && space_s;
    b_ready_s = (state_r == GNT_B) && space_s;
    a_acc_s   = a_valid && a_ready_s;
    b_acc_s   = b_valid && b_ready_s;
    at_last_s = (beat_cnt_r == LAST_BEAT);
  end

  assign a_ready   = a_ready_s;
  assign b_ready   = b_ready_s;
  assign sel       = sel_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

  // Grant decision: at most one of go_a/go_b/go_idle is set; none set means hold the current grant.
  always_comb begin
    go_a_s    = 1'b0;
    go_b_s    = 1'b0;
    go_idle_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (a_valid && b_valid) begin
          go_a_s = last_b_r;
          go_b_s = !last_b_r;
        end else if (a_valid) begin
          go_a_s = 1'b1;
        end else if (b_valid) begin
          go_b_s = 1'b1;
        end else begin
          go_idle_s = 1'b0;
        end
      end
      GNT_A: begin
        if (a_acc_s && at_last_s) begin
          if (b_valid) begin
            go_b_s = 1'b1;
          end else if (a_valid) begin
            go_a_s = 1'b1;
          end else begin
            go_idle_s = 1'b1;
          end
        end else if (!a_valid) begin
          if (b_valid) begin
            go_b_s = 1'b1;
          end else begin
            go_idle_s = 1'b1;
          end
        end else begin
          go_idle_s = 1'b0;
        end
      end
      GNT_B: begin
        if (b_acc_s && at_last_s) begin
          if (a_valid) begin
            go_a_s = 1'b1;
          end else if (b_valid) begin
            go_b_s = 1'b1;
          end else begin
            go_idle_s = 1'b1;
          end
        end else if (!b_valid) begin
          if (a_valid) begin
            go_a_s = 1'b1;
          end else begin
            go_idle_s = 1'b1;
          end
        end else begin
          go_idle_s = 1'b0;
        end
      end
      default: begin
        go_idle_s = 1'b1;
      end
    endcase
  end

  // Grant FSM; every grant entry (including a burst restart) clears the beat count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      sel_r      <= 1'b0;
      last_b_r   <= 1'b1;
      beat_cnt_r <= 8'd0;
    end else if (go_a_s) begin
      state_r    <= GNT_A;
      sel_r      <= 1'b0;
      last_b_r   <= 1'b0;
      beat_cnt_r <= 8'd0;
    end else if (go_b_s) begin
      state_r    <= GNT_B;
      sel_r      <= 1'b1;
      last_b_r   <= 1'b1;
      beat_cnt_r <= 8'd0;
    end else if (go_idle_s) begin
      state_r    <= IDLE;
      sel_r      <= 1'b0;
      last_b_r   <= last_b_r;
      beat_cnt_r <= 8'd0;
    end else if (a_acc_s || b_acc_s) begin
      beat_cnt_r <= beat_cnt_r + 8'd1;
    end else begin
      beat_cnt_r <= beat_cnt_r;
    end
  end

  // Output register: a new accept wins over a drain in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else if (a_acc_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= a_data;
    end else if (b_acc_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= b_data;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

`ifdef MUX2_ARB_GRANT_CNT_EN
  logic [15:0] a_grant_cnt_r;
  logic [15:0] b_grant_cnt_r;

  // Accepted-beat counters; clear has priority and the increment wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_grant_cnt_r <= 16'd0;
      b_grant_cnt_r <= 16'd0;
    end else if (cnt_clr) begin
      a_grant_cnt_r <= 16'd0;
      b_grant_cnt_r <= 16'd0;
    end else begin
      a_grant_cnt_r <= a_grant_cnt_r + {15'd0, a_acc_s};
      b_grant_cnt_r <= b_grant_cnt_r + {15'd0, b_acc_s};
    end
  end

  assign a_grant_cnt = a_grant_cnt_r;
  assign b_grant_cnt = b_grant_cnt_r;
`endif

endmodule

// File: tb/tb_mux2_burst_arbiter.sv
// Directed scoreboard bench for mux2_burst_arbiter (BURST=4); covers counters when MUX2_ARB_GRANT_CNT_EN is set.
`timescale 1ns/1ps
module tb_mux2_burst_arbiter;
  localparam int WIDTH = 8;
  localparam int BURST = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             a_valid, b_valid, a_ready, b_ready;
  logic [WIDTH-1:0] a_data, b_data, out_data;
  logic             sel, out_valid, out_ready;
`ifdef MUX2_ARB_GRANT_CNT_EN
  logic             cnt_clr;
  logic [15:0]      a_grant_cnt, b_grant_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] a_src[$];
  logic [7:0] b_src[$];
  logic [7:0] sb[$];
  logic a_fire = 1'b0;
  logic b_fire = 1'b0;
  logic rdy = 1'b1;

  mux2_burst_arbiter #(.WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
`ifdef MUX2_ARB_GRANT_CNT_EN
    , .cnt_clr(cnt_clr), .a_grant_cnt(a_grant_cnt), .b_grant_cnt(b_grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every beat the consumer takes must be the next expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      chk("sb_nonempty", 16'(sb.size() != 0), 16'd1);
      if (sb.size() != 0) chk("out_data_sb", 16'(out_data), 16'(sb.pop_front()));
    end
  end

  // One clock: retire accepted beats, present source heads, return at the following negedge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (a_fire) void'(a_src.pop_front());
    if (b_fire) void'(b_src.pop_front());
    a_valid   = (a_src.size() != 0);
    a_data    = a_valid ? a_src[0] : 8'h00;
    b_valid   = (b_src.size() != 0);
    b_data    = b_valid ? b_src[0] : 8'h00;
    out_ready = rdy;
    @(negedge clk);
    a_fire = a_valid && a_ready;
    b_fire = b_valid && b_ready;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || a_src.size() != 0 || b_src.size() != 0) && n < budget) begin
      tick();
      #1;
      n++;
    end
    chk("drain_done", 16'(sb.size()), 16'd0);
    repeat (3) tick();
  endtask

  initial begin
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_data = 8'h00; b_data = 8'h00; out_ready = 1'b1;
`ifdef MUX2_ARB_GRANT_CNT_EN
    cnt_clr = 1'b0;
`endif
    #2;
    chk("rst_sel", 16'(sel), 16'd0);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_out_data", 16'(out_data), 16'd0);
    chk("rst_a_ready", 16'(a_ready), 16'd0);
    chk("rst_b_ready", 16'(b_ready), 16'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // A only: 0x11,0x22,0x33 appear in cycles 2,3,4
    a_src = '{8'h11, 8'h22, 8'h33};
    sb = '{8'h11, 8'h22, 8'h33};
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("a_only_sel", 16'(sel), 16'd0);
      chk("a_only_b_ready", 16'(b_ready), 16'd0);
      chk("a_only_a_ready", 16'(a_ready), 16'(c != 0));
      chk("a_only_out_valid", 16'(out_valid), 16'(c >= 2));
      if (c >= 2) chk("a_only_out_data", 16'(out_data), 16'(8'(8'h11 * (c - 1))));
    end
    tick();
    chk("a_only_drained", 16'(out_valid), 16'd0);

    // Tie with last_served=A: B first, then A after the release
    a_src.push_back(8'hA1); b_src.push_back(8'hB1);
    sb.push_back(8'hB1); sb.push_back(8'hA1);
    tick();
    chk("tie_idle_sel", 16'(sel), 16'd0);
    tick();
    chk("tie_b_first_sel", 16'(sel), 16'd1);
    chk("tie_b_first_ready", 16'(b_ready), 16'd1);
    tick(); tick();
    chk("tie_then_a_sel", 16'(sel), 16'd0);
    chk("tie_then_a_ready", 16'(a_ready), 16'd1);
    tick(); tick();
    chk("tie_idle_after", 16'(out_valid), 16'd0);

    // Single B beat leaves last_served=B
    b_src.push_back(8'hB2); sb.push_back(8'hB2);
    tick(); tick();
    chk("single_b_sel", 16'(sel), 16'd1);
    tick(); tick();
    chk("single_b_idle_sel", 16'(sel), 16'd0);

    // Continuous A and B: sel 0,0,0,0,1,1,1,1,... with no output bubbles
    for (int i = 0; i < 8; i++) begin
      a_src.push_back(8'(8'h40 + i));
      b_src.push_back(8'(8'h80 + i));
    end
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 4; i++) sb.push_back(8'(8'h40 + 4 * g + i));
      for (int i = 0; i < 4; i++) sb.push_back(8'(8'h80 + 4 * g + i));
    end
    tick();
    chk("cont_idle_sel", 16'(sel), 16'd0);
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("cont_sel", 16'(sel), 16'((k >> 2) & 1));
      if (k > 0) chk("cont_no_bubble", 16'(out_valid), 16'd1);
    end
    tick();
    chk("cont_last_valid", 16'(out_valid), 16'd1);
    drain(40);

    // Backpressure mid-burst with B waiting: burst still ends after exactly 4 A beats
    for (int i = 0; i < 6; i++) a_src.push_back(8'(8'hC0 + i));
    b_src.push_back(8'hD0);
    sb = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hD0, 8'hC4, 8'hC5};
    tick(); tick(); tick(); tick();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_a_ready", 16'(a_ready), 16'd0);
      chk("bp_out_valid", 16'(out_valid), 16'd1);
      chk("bp_out_data", 16'(out_data), 16'hC2);
      chk("bp_sel", 16'(sel), 16'd0);
    end
    rdy = 1'b1;
    tick();
    chk("bp_resume_a_ready", 16'(a_ready), 16'd1);
    chk("bp_resume_sel", 16'(sel), 16'd0);
    tick();
    chk("bp_switch_sel", 16'(sel), 16'd1);
    chk("bp_switch_b_ready", 16'(b_ready), 16'd1);
    drain(40);

    // Release: A drops after 2 beats while B waits
    a_src = '{8'hE0, 8'hE1};
    sb = '{8'hE0, 8'hE1, 8'hF0, 8'hF1};
    tick();
    b_src = '{8'hF0, 8'hF1};
    tick();
    chk("rel_grant_a", 16'(sel), 16'd0);
    tick(); tick();
    chk("rel_still_a", 16'(sel), 16'd0);
    chk("rel_b_ready_low", 16'(b_ready), 16'd0);
    tick();
    chk("rel_sel_b", 16'(sel), 16'd1);
    chk("rel_b_ready", 16'(b_ready), 16'd1);
    drain(40);

    // Reset in the middle of a B burst with a beat held in the output register
    b_src = '{8'h90, 8'h91, 8'h92, 8'h93};
    sb = '{8'h90, 8'h91, 8'h92, 8'h93};
    tick(); tick(); tick();
    chk("mid_sel", 16'(sel), 16'd1);
    chk("mid_out_valid", 16'(out_valid), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 16'(out_valid), 16'd0);
    chk("mid_rst_sel", 16'(sel), 16'd0);
    chk("mid_rst_out_data", 16'(out_data), 16'd0);
    chk("mid_rst_b_ready", 16'(b_ready), 16'd0);
`ifdef MUX2_ARB_GRANT_CNT_EN
    chk("rst_a_cnt", a_grant_cnt, 16'd0);
    chk("rst_b_cnt", b_grant_cnt, 16'd0);
`endif
    a_src.delete(); b_src.delete(); sb.delete();
    a_fire = 1'b0; b_fire = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; a_data = 8'h00; b_data = 8'h00;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // After reset last_served=B, so A wins the first tie
    a_src.push_back(8'h5A); b_src.push_back(8'h5B);
    sb.push_back(8'h5A); sb.push_back(8'h5B);
    tick(); tick();
    chk("post_rst_tie_sel", 16'(sel), 16'd0);
    chk("post_rst_tie_a_ready", 16'(a_ready), 16'd1);
    drain(40);

`ifdef MUX2_ARB_GRANT_CNT_EN
    chk("cnt_a_after_tie", a_grant_cnt, 16'd1);
    chk("cnt_b_after_tie", b_grant_cnt, 16'd1);
    for (int i = 0; i < 5; i++) begin
      a_src.push_back(8'(8'h20 + i));
      sb.push_back(8'(8'h20 + i));
    end
    drain(40);
    chk("cnt_a_after_5", a_grant_cnt, 16'd6);
    @(posedge clk);
    #1 cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    chk("cnt_a_clr", a_grant_cnt, 16'd0);
    chk("cnt_b_clr", b_grant_cnt, 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
